// File: rtl/usb_bit_stuffer.sv
// USB bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s,
// stalling the CRC stage through bs_ready while the stuffed 0 goes out.
module usb_bit_stuffer #(
  parameter int RUN_LEN = 6,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             bs_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             pkt_done,
  output logic [CNT_W-1:0] stuff_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    STUFF
  } state_e;

  localparam logic [3:0] RUN_M1 = 4'(RUN_LEN - 1);

  state_e           state_q, state_d;
  logic [3:0]       ones_q, ones_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             pkt_done_q, pkt_done_d;
  logic             done_pend_q, done_pend_d;
  logic [CNT_W-1:0] stuff_q, stuff_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ones_q      <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      done_pend_q <= 1'b0;
      stuff_q     <= '0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      pkt_done_q  <= pkt_done_d;
      done_pend_q <= done_pend_d;
      stuff_q     <= stuff_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    pkt_done_d  = 1'b0;
    done_pend_d = 1'b0;
    stuff_d     = stuff_q;
    unique case (state_q)
      IDLE: begin
        ones_d     = '0;
        // a packet that ended on a stuffed 0 reports done one cycle later
        pkt_done_d = done_pend_q;
        if (in_valid) begin
          state_d     = PASS;
          stuff_d     = '0;
          out_bit_d   = in_bit;
          out_valid_d = 1'b1;
          ones_d      = {3'b000, in_bit};
        end
      end
      PASS: begin
        if (in_valid) begin
          out_bit_d   = in_bit;
          out_valid_d = 1'b1;
          if (!in_bit) begin
            ones_d = '0;
          end else if (ones_q == RUN_M1) begin
            state_d = STUFF;
            ones_d  = '0;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          state_d    = IDLE;
          pkt_done_d = 1'b1;
          ones_d     = '0;
        end
      end
      STUFF: begin
        out_bit_d   = 1'b0;
        out_valid_d = 1'b1;
        ones_d      = '0;
        if (stuff_q != '1) begin
          stuff_d = stuff_q + CNT_W'(1);
        end
        if (in_valid) begin
          state_d = PASS;
        end else begin
          state_d     = IDLE;
          done_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bs_ready  = (state_q != STUFF);
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign pkt_done  = pkt_done_q;
  assign stuff_cnt = stuff_q;

endmodule

// File: doc/usb_bit_stuffer.md
Name: usb_bit_stuffer

Overview:
- Serial stage directly downstream of the CRC16 calculator. Sits between the CRC stage and the NRZI encoder.
- Accepts the packet bitstream (PID, payload, then CRC16) one bit per accepted cycle and re-emits it.
- After every RUN_LEN consecutive 1s it inserts a 0.
- Stalls the upstream stage through bs_ready while the inserted 0 goes out.

Parameters:
- RUN_LEN, 6: number of consecutive 1s that triggers a stuffed 0. Legal range 2..15.
- CNT_W, 8: width of the per-packet stuffed-bit counter.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream is presenting a packet bit (the CRC stage's crc_valid_out). High for the whole packet, low between packets.
- in_bit  input  1  packet bit (the CRC stage's out_bit). Sampled only on accept.
- bs_ready  output  1  this block can accept a bit this cycle.
- out_bit  output  1  registered stuffed bitstream to the NRZI encoder.
- out_valid  output  1  out_bit is a real bit this cycle.
- pkt_done  output  1  one-cycle pulse after the final bit of a packet (including any trailing stuff bit) has been emitted.
- stuff_cnt  output  CNT_W  stuffed 0s inserted in the current or most recent packet. Saturates at all-ones.

Behaviour:
- Accept: in_valid && bs_ready at a posedge. A bit accepted at edge N appears on out_bit with out_valid=1 in the cycle after edge N (1-cycle latency).
- bs_ready is a pure decode of state: 1 in IDLE and PASS, 0 in STUFF. It has no combinational path from in_valid or in_bit.
- ones_cnt, width 4:
  - An accepted 1 increments it.
  - An accepted 0 clears it.
  - Entering STUFF clears it; the stuffed 0 breaks the run.
- State IDLE:
  - bs_ready=1, out_valid=0, ones_cnt held at 0.
  - On accept: go to PASS, clear stuff_cnt, register the bit.
- State PASS:
  - On accept where the accepted bit is 1 and ones_cnt==RUN_LEN-1: register the bit and go to STUFF.
  - Otherwise on accept: register the bit and stay in PASS.
  - If in_valid=0: out_valid=0 next cycle, pulse pkt_done next cycle, go to IDLE, clear ones_cnt.
- State STUFF (lasts exactly 1 cycle):
  - The edge leaving STUFF registers out_bit=0, out_valid=1 and increments stuff_cnt (saturating).
  - Next state is PASS if in_valid=1, else IDLE. When going to IDLE, pkt_done pulses in the cycle after the stuffed 0 is emitted.
  - The stuff bit is always emitted, even when the run completes on the final packet bit; USB requires the trailing stuff.
- Upstream contract: the CRC stage pauses (holds in_bit and in_valid) while bs_ready=0. This block neither drops nor duplicates a bit across a stall.
- in_valid low for 1 cycle mid-stream is treated as end of packet. ones_cnt resets; the next high starts a new packet.
- Reset values, while reset_n=0 and after release:
  - state=IDLE, bs_ready=1, out_bit=0, out_valid=0, pkt_done=0, stuff_cnt=0, ones_cnt=0.
  - Reset asserted mid-packet or mid-STUFF discards the pending bit with no pkt_done.
- stuff_cnt holds its value after the packet until the next packet's first accept.

Test Plan:
- 16 bits 0x5A5A LSB-first, in_valid held high -> 16 out_valid cycles reproducing the input, bs_ready never low, stuff_cnt=0, pkt_done 1 cycle after the last bit.
- Input bits 1111111 then 0 (8 bits) -> output 1111110 1 0 (9 bits). bs_ready low for exactly 1 cycle after the 6th 1 is accepted; stuff_cnt=1.
- 12 consecutive 1s ending the packet -> output 111111 0 111111 0 (14 bits), stuff_cnt=2, pkt_done after the final stuffed 0.
- Run of 5 ones, a 0, then 5 ones -> no stuffing; ones_cnt clears on the 0; stuff_cnt=0.
- Upstream honours the stall: stream 0x00FF,0xFF00 pattern through → compare the output against a reference stuffer model bit-for-bit, checking no loss or duplication.
- reset_n pulsed low during STUFF -> next cycle bs_ready=1, out_valid=0, stuff_cnt=0, no pkt_done. A subsequent packet is processed from ones_cnt=0.
